// File: rtl/locked_rr_req_arbiter_bridge.sv
// Round-robin N-to-1 request arbiter with burst lock for the bridge request path.
// Selection is combinational from registered pointer/owner state; lock bursts end on lock drop, MAX_BURST or idle timeout.
module locked_rr_req_arbiter_bridge #(
    parameter int N_MASTER     = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 20,
    parameter int MAX_BURST    = 8,
    parameter int LOCK_TIMEOUT = 16,
    localparam int LOG_MASTER  = $clog2(N_MASTER)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER-1:0]            data_lock_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]            data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic                           data_wen_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic [BE_WIDTH-1:0]            data_be_o,
    output logic [ID_WIDTH-1:0]            data_ID_o,
    input  logic                           data_gnt_i,
    output logic [LOG_MASTER-1:0]          sel_idx_o,
    output logic                           locked_o,
    output logic                           lock_abort_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e                state_q, state_d;
    logic [LOG_MASTER-1:0] ptr_q, ptr_d;
    logic [LOG_MASTER-1:0] owner_q, owner_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  abort_q, abort_d;

    logic                  rr_found;
    logic [LOG_MASTER-1:0] rr_sel;
    logic [LOG_MASTER-1:0] sel;
    logic                  req_sel;
    logic                  hs;
    int                    cand;

    function automatic logic [LOG_MASTER-1:0] next_idx(input logic [LOG_MASTER-1:0] idx);
        if (idx == LOG_MASTER'(N_MASTER - 1)) begin
            return '0;
        end
        return idx + LOG_MASTER'(1);
    endfunction

    always_comb begin
        rr_found = 1'b0;
        rr_sel   = ptr_q;
        cand     = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_MASTER) begin
                cand = cand - N_MASTER;
            end
            if (!rr_found && data_req_i[LOG_MASTER'(cand)]) begin
                rr_found = 1'b1;
                rr_sel   = LOG_MASTER'(cand);
            end
        end
    end

    // While reset is asserted the request path is forced quiet regardless of master inputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        abort_d = 1'b0;
        sel     = ptr_q;
        req_sel = 1'b0;

        if (state_q == ARB) begin
            sel     = rr_sel;
            req_sel = rr_found;
        end else begin
            sel     = owner_q;
            req_sel = data_req_i[owner_q];
        end

        sel_idx_o  = rst_n ? sel : '0;
        data_req_o = rst_n & req_sel;
        hs         = data_req_o & data_gnt_i;

        if (state_q == ARB) begin
            if (hs) begin
                if (!data_lock_i[sel]) begin
                    ptr_d = next_idx(sel);
                end else if (MAX_BURST == 1) begin
                    ptr_d   = next_idx(sel);
                    abort_d = 1'b1;
                end else begin
                    state_d = LOCKED;
                    owner_d = sel;
                    burst_d = BW'(1);
                    idle_d  = '0;
                end
            end
        end else begin
            if (data_req_i[owner_q]) begin
                idle_d = '0;
            end
            if (hs) begin
                if (!data_lock_i[owner_q]) begin
                    state_d = ARB;
                    ptr_d   = next_idx(owner_q);
                end else begin
                    burst_d = burst_q + BW'(1);
                    if (burst_d == BW'(MAX_BURST)) begin
                        state_d = ARB;
                        ptr_d   = next_idx(owner_q);
                        abort_d = 1'b1;
                    end
                end
            end else if (!data_req_i[owner_q]) begin
                idle_d = idle_q + IW'(1);
                if (idle_d == IW'(LOCK_TIMEOUT)) begin
                    state_d = ARB;
                    ptr_d   = next_idx(owner_q);
                    abort_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_gnt_o = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            data_gnt_o[i] = data_gnt_i & data_req_o & (sel_idx_o == LOG_MASTER'(i));
        end
    end

    assign data_add_o   = data_add_i[sel_idx_o*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_wen_o   = data_wen_i[sel_idx_o];
    assign data_wdata_o = data_wdata_i[sel_idx_o*DATA_WIDTH +: DATA_WIDTH];
    assign data_be_o    = data_be_i[sel_idx_o*BE_WIDTH +: BE_WIDTH];
    assign data_ID_o    = data_ID_i[sel_idx_o*ID_WIDTH +: ID_WIDTH];
    assign locked_o     = (state_q == LOCKED);
    assign lock_abort_o = abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            idle_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_locked_rr_req_arbiter_bridge.sv
// Directed bench: a 4-master arbiter (MAX_BURST=8, LOCK_TIMEOUT=16) and a 3-master one (MAX_BURST=1).
// Inputs change one time unit after each rising edge and outputs are checked one unit later.
module tb_locked_rr_req_arbiter_bridge;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [3:0]     req4, lock4, wen4, gnto4;
    logic [4*32-1:0] add4, wdata4;
    logic [4*4-1:0]  be4;
    logic [4*20-1:0] id4;
    logic            gnti4, reqo4, weno4, locked4, abort4;
    logic [31:0]     addo4, wdatao4;
    logic [3:0]      beo4;
    logic [19:0]     ido4;
    logic [1:0]      sel4;

    logic [2:0]      req3, lock3, wen3, gnto3;
    logic [3*32-1:0] add3, wdata3;
    logic [3*4-1:0]  be3;
    logic [3*20-1:0] id3;
    logic            gnti3, reqo3, weno3, locked3, abort3;
    logic [31:0]     addo3, wdatao3;
    logic [3:0]      beo3;
    logic [19:0]     ido3;
    logic [1:0]      sel3;

    logic [8:0]  obs4;
    logic [7:0]  obs3;
    logic [88:0] fld4;
    logic [88:0] fld3;

    assign obs4 = {sel4, locked4, abort4, reqo4, gnto4};
    assign obs3 = {sel3, locked3, abort3, reqo3, gnto3};
    assign fld4 = {addo4, weno4, wdatao4, beo4, ido4};
    assign fld3 = {addo3, weno3, wdatao3, beo3, ido3};

    locked_rr_req_arbiter_bridge #(
        .N_MASTER(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(20),
        .MAX_BURST(8), .LOCK_TIMEOUT(16)
    ) dut4 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req4), .data_lock_i(lock4), .data_add_i(add4), .data_wen_i(wen4),
        .data_wdata_i(wdata4), .data_be_i(be4), .data_ID_i(id4),
        .data_gnt_o(gnto4), .data_req_o(reqo4), .data_add_o(addo4), .data_wen_o(weno4),
        .data_wdata_o(wdatao4), .data_be_o(beo4), .data_ID_o(ido4),
        .data_gnt_i(gnti4), .sel_idx_o(sel4), .locked_o(locked4), .lock_abort_o(abort4)
    );

    locked_rr_req_arbiter_bridge #(
        .N_MASTER(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(20),
        .MAX_BURST(1), .LOCK_TIMEOUT(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req3), .data_lock_i(lock3), .data_add_i(add3), .data_wen_i(wen3),
        .data_wdata_i(wdata3), .data_be_i(be3), .data_ID_i(id3),
        .data_gnt_o(gnto3), .data_req_o(reqo3), .data_add_o(addo3), .data_wen_o(weno3),
        .data_wdata_o(wdatao3), .data_be_o(beo3), .data_ID_o(ido3),
        .data_gnt_i(gnti3), .sel_idx_o(sel3), .locked_o(locked3), .lock_abort_o(abort3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] exp4(input logic [1:0] s, input logic lk, input logic ab,
                                        input logic rq, input logic [3:0] g);
        return {s, lk, ab, rq, g};
    endfunction

    function automatic logic [7:0] exp3(input logic [1:0] s, input logic lk, input logic ab,
                                        input logic rq, input logic [2:0] g);
        return {s, lk, ab, rq, g};
    endfunction

    // Master i drives address A000_000i, data D000_000i, be i+1, ID 5000i; wen pattern 0101.
    function automatic logic [88:0] fields(input int i);
        logic [3:0] wenPat;
        wenPat = 4'b0101;
        return {32'hA000_0000 + 32'(i), wenPat[i], 32'hD000_0000 + 32'(i), 4'(i + 1), 20'h5_0000 + 20'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req4 = 4'b1111; lock4 = 4'b0000; gnti4 = 1'b1;
        req3 = 3'b111;  lock3 = 3'b000;  gnti3 = 1'b1;
        #2;
        total++;
        if (obs4 !== exp4(2'd0, 0, 0, 0, 4'b0000)) begin
            bad++;
            $display("[TB] FAIL reset4: got %b expected %b", obs4, exp4(2'd0, 0, 0, 0, 4'b0000));
        end
        total++;
        if (obs3 !== exp3(2'd0, 0, 0, 0, 3'b000)) begin
            bad++;
            $display("[TB] FAIL reset3: got %b expected %b", obs3, exp3(2'd0, 0, 0, 0, 3'b000));
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req4 = '0; req3 = '0; gnti4 = 1'b0; gnti3 = 1'b0;
    endtask

    task automatic test_round_robin();
        req4 = 4'b1111; lock4 = 4'b0000; gnti4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (obs4 !== exp4(2'(c % 4), 0, 0, 1, 4'b0001 << (c % 4))) begin
                bad++;
                $display("[TB] FAIL rr c=%0d: got %b expected %b", c, obs4, exp4(2'(c % 4), 0, 0, 1, 4'b0001 << (c % 4)));
            end
            total++;
            if (fld4 !== fields(c % 4)) begin
                bad++;
                $display("[TB] FAIL rr_fields c=%0d: got %h expected %h", c, fld4, fields(c % 4));
            end
            tick();
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] lockSeq;
        req4 = 4'b0010; lock4 = 4'b0000; gnti4 = 1'b1;
        tick();
        lockSeq = 4'b0111;
        req4 = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            lock4 = {1'b0, lockSeq[c], 2'b00};
            #1;
            total++;
            if (obs4 !== exp4(2'd2, (c > 0), 0, 1, 4'b0100)) begin
                bad++;
                $display("[TB] FAIL lock_burst c=%0d: got %b expected %b", c, obs4, exp4(2'd2, (c > 0), 0, 1, 4'b0100));
            end
            tick();
        end
        lock4 = 4'b0000;
        #1;
        total++;
        if (obs4 !== exp4(2'd0, 0, 0, 1, 4'b0001)) begin
            bad++;
            $display("[TB] FAIL lock_after: got %b expected %b", obs4, exp4(2'd0, 0, 0, 1, 4'b0001));
        end
        tick();
    endtask

    task automatic test_max_burst();
        req4 = 4'b0110; lock4 = 4'b0010; gnti4 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            total++;
            if (obs4 !== exp4(2'd1, (c > 1), 0, 1, 4'b0010)) begin
                bad++;
                $display("[TB] FAIL max_burst hs=%0d: got %b expected %b", c, obs4, exp4(2'd1, (c > 1), 0, 1, 4'b0010));
            end
            tick();
        end
        #1;
        total++;
        if (obs4 !== exp4(2'd2, 0, 1, 1, 4'b0100)) begin
            bad++;
            $display("[TB] FAIL max_burst_abort: got %b expected %b", obs4, exp4(2'd2, 0, 1, 1, 4'b0100));
        end
        tick();
        req4 = 4'b0000; lock4 = 4'b0000; gnti4 = 1'b0;
        #1;
        total++;
        if (obs4 !== exp4(2'd3, 0, 0, 0, 4'b0000)) begin
            bad++;
            $display("[TB] FAIL max_burst_after: got %b expected %b", obs4, exp4(2'd3, 0, 0, 0, 4'b0000));
        end
        tick();
    endtask

    task automatic test_timeout();
        req4 = 4'b1000; lock4 = 4'b1000; gnti4 = 1'b1;
        tick();
        req4 = 4'b0001; lock4 = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            #1;
            total++;
            if (obs4 !== exp4(2'd3, 1, 0, 0, 4'b0000)) begin
                bad++;
                $display("[TB] FAIL timeout idle=%0d: got %b expected %b", c, obs4, exp4(2'd3, 1, 0, 0, 4'b0000));
            end
            tick();
        end
        #1;
        total++;
        if (obs4 !== exp4(2'd0, 0, 1, 1, 4'b0001)) begin
            bad++;
            $display("[TB] FAIL timeout_abort: got %b expected %b", obs4, exp4(2'd0, 0, 1, 1, 4'b0001));
        end
        tick();
        req4 = 4'b0000; gnti4 = 1'b0;
        #1;
        total++;
        if (obs4 !== exp4(2'd1, 0, 0, 0, 4'b0000)) begin
            bad++;
            $display("[TB] FAIL timeout_after: got %b expected %b", obs4, exp4(2'd1, 0, 0, 0, 4'b0000));
        end
        tick();
    endtask

    task automatic test_stall_and_reset();
        req4 = 4'b0100; lock4 = 4'b0100; gnti4 = 1'b1;
        tick();
        // Stalled cycles must not advance the burst count: seven more handshakes reach MAX_BURST.
        req4 = 4'b0110; gnti4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (obs4 !== exp4(2'd2, 1, 0, 1, 4'b0000) || fld4 !== fields(2)) begin
                bad++;
                $display("[TB] FAIL stall c=%0d: got %b/%h expected %b/%h", c, obs4, fld4, exp4(2'd2, 1, 0, 1, 4'b0000), fields(2));
            end
            tick();
        end
        gnti4 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            #1;
            total++;
            if (obs4 !== exp4(2'd2, 1, 0, 1, 4'b0100)) begin
                bad++;
                $display("[TB] FAIL stall_resume hs=%0d: got %b expected %b", c, obs4, exp4(2'd2, 1, 0, 1, 4'b0100));
            end
            tick();
        end
        req4 = 4'b0100;
        #1;
        total++;
        if (obs4 !== exp4(2'd2, 0, 1, 1, 4'b0100)) begin
            bad++;
            $display("[TB] FAIL stall_abort: got %b expected %b", obs4, exp4(2'd2, 0, 1, 1, 4'b0100));
        end
        tick();
        req4 = 4'b0110; gnti4 = 1'b0;
        #1;
        total++;
        if (obs4 !== exp4(2'd2, 1, 0, 1, 4'b0000)) begin
            bad++;
            $display("[TB] FAIL relock: got %b expected %b", obs4, exp4(2'd2, 1, 0, 1, 4'b0000));
        end
        gnti4 = 1'b1;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs4 !== exp4(2'd0, 0, 0, 0, 4'b0000)) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b expected %b", obs4, exp4(2'd0, 0, 0, 0, 4'b0000));
        end
        tick();
        total++;
        if (obs4 !== exp4(2'd0, 0, 0, 0, 4'b0000)) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b expected %b", obs4, exp4(2'd0, 0, 0, 0, 4'b0000));
        end
        rst_n = 1'b1;
        lock4 = 4'b0000;
        #1;
        total++;
        if (obs4 !== exp4(2'd1, 0, 0, 1, 4'b0010)) begin
            bad++;
            $display("[TB] FAIL post_reset: got %b expected %b", obs4, exp4(2'd1, 0, 0, 1, 4'b0010));
        end
        tick();
        req4 = 4'b0000; gnti4 = 1'b0;
    endtask

    task automatic test_n3_wrap();
        logic [2:0] reqV  [8];
        logic [2:0] lockV [8];
        logic [7:0] expV  [8];
        reqV  = '{3'b010, 3'b011, 3'b000, 3'b100, 3'b111, 3'b011, 3'b011, 3'b000};
        lockV = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
        expV  = '{exp3(2'd1, 0, 0, 1, 3'b010), exp3(2'd0, 0, 0, 1, 3'b001),
                  exp3(2'd1, 0, 0, 0, 3'b000), exp3(2'd2, 0, 0, 1, 3'b100),
                  exp3(2'd0, 0, 0, 1, 3'b001), exp3(2'd1, 0, 0, 1, 3'b010),
                  exp3(2'd0, 0, 1, 1, 3'b001), exp3(2'd1, 0, 0, 0, 3'b000)};
        gnti3 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req3  = reqV[c];
            lock3 = lockV[c];
            #1;
            total++;
            if (obs3 !== expV[c]) begin
                bad++;
                $display("[TB] FAIL n3 c=%0d: got %b expected %b", c, obs3, expV[c]);
            end
            if (c == 4) begin
                total++;
                if (fld3 !== fields(0)) begin
                    bad++;
                    $display("[TB] FAIL n3_fields: got %h expected %h", fld3, fields(0));
                end
            end
            tick();
        end
        req3 = '0; gnti3 = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) begin
            add4[i*32 +: 32]   = 32'hA000_0000 + 32'(i);
            wdata4[i*32 +: 32] = 32'hD000_0000 + 32'(i);
            be4[i*4 +: 4]      = 4'(i + 1);
            id4[i*20 +: 20]    = 20'h5_0000 + 20'(i);
        end
        wen4 = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            add3[i*32 +: 32]   = 32'hA000_0000 + 32'(i);
            wdata3[i*32 +: 32] = 32'hD000_0000 + 32'(i);
            be3[i*4 +: 4]      = 4'(i + 1);
            id3[i*20 +: 20]    = 20'h5_0000 + 20'(i);
        end
        wen3 = 3'b101;

        test_reset();
        test_round_robin();
        test_lock_burst();
        test_max_burst();
        test_timeout();
        test_stall_and_reset();
        test_n3_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
